i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target_if.sv | 15 +
 rtl/i2c_target.sv | 170 +++++++++++++++++
 tb/tb_i2c_target.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_target_if.sv
// i2c_target_if: pad-side I2C lines and register-write/status signals of the I2C target
interface i2c_target_if #(
    parameter int REG_AW = 4
);
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic [3:0]        state_out;
    logic              wr_strobe;
    logic [REG_AW-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    modport slave  (input scl_in, sda_in, output sda_oe, state_out, wr_strobe, wr_addr, wr_data, busy);
    modport master (output scl_in, sda_in, input sda_oe, state_out, wr_strobe, wr_addr, wr_data, busy);
endinterface

// File: rtl/i2c_target.sv
// i2c_target: I2C target with a byte-wide register file, auto-incrementing pointer and write strobe
module i2c_target #(
    parameter logic [6:0] DEV_ADDR = 7'h39,
    parameter int         REG_AW   = 4
) (
    input logic         clk_ref,
    input logic         reset_n,
    i2c_target_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, ADDR = 4'd1, ADDR_ACK = 4'd2, PTR = 4'd3, PTR_ACK = 4'd4,
        WDATA = 4'd5, WDATA_ACK = 4'd6, RDATA = 4'd7, RDATA_ACK = 4'd8, WAIT_STOP = 4'd9
    } state_t;
    localparam int DEPTH = 1 << REG_AW;
    localparam logic [REG_AW-1:0] PTR_ONE = 1;
    logic [2:0]        r_scl, r_sda;
    state_t            r_state, w_state;
    logic [3:0]        r_cnt, w_cnt;
    logic [7:0]        r_shift, w_shift;
    logic [REG_AW-1:0] r_ptr, w_ptr;
    logic              r_sda_oe, w_oe;
    logic              r_busy, w_busy;
    logic              r_ptr_seen, w_ptr_seen;
    logic              r_rw, w_rw;
    logic              r_wr_strobe;
    logic [REG_AW-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_regs [DEPTH];
    logic              w_we;
    logic              w_scl, w_scl_h, w_sda;
    logic              w_rise, w_fall, w_start, w_stop, w_match;
    logic [7:0]        w_byte, w_rd_byte;
    assign w_scl     = r_scl[1];
    assign w_scl_h   = r_scl[2];
    assign w_sda     = r_sda[1];
    assign w_rise    = w_scl & ~w_scl_h;
    assign w_fall    = ~w_scl & w_scl_h;
    assign w_start   = w_scl & w_scl_h & r_sda[2] & ~w_sda;
    assign w_stop    = w_scl & w_scl_h & ~r_sda[2] & w_sda;
    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_rd_byte = r_regs[r_ptr];
    assign w_match   = r_shift[7:1] == DEV_ADDR;
    assign bus.sda_oe    = r_sda_oe;
    assign bus.state_out = r_state;
    assign bus.wr_strobe = r_wr_strobe;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = r_busy;
    // Two sync flops plus a history flop per pad line; idle-high reset avoids false edges
    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            r_scl <= 3'b111;
            r_sda <= 3'b111;
        end else begin
            r_scl <= {r_scl[1:0], bus.scl_in};
            r_sda <= {r_sda[1:0], bus.sda_in};
        end
    end
    // Next-state logic: START/STOP win, bits shift in on SCL rise, SDA changes on SCL fall
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_shift    = r_shift;
        w_ptr      = r_ptr;
        w_oe       = r_sda_oe;
        w_busy     = r_busy;
        w_ptr_seen = r_ptr_seen;
        w_rw       = r_rw;
        w_we       = 1'b0;
        if (w_start) begin
            w_state = ADDR;
            w_cnt   = 4'd0;
            w_oe    = 1'b0;
        end else if (w_stop) begin
            w_state    = IDLE;
            w_oe       = 1'b0;
            w_busy     = 1'b0;
            w_ptr_seen = 1'b0;
        end else if (r_state != IDLE && r_state != WAIT_STOP) begin
            if (w_rise) begin
                w_shift = w_byte;
                w_cnt   = r_cnt + 4'd1;
                w_we    = r_state == WDATA && r_cnt == 4'd7;
                w_ptr   = w_we ? r_ptr + PTR_ONE : r_ptr;
            end else if (w_fall) begin
                case (r_state)
                    ADDR: if (r_cnt == 4'd8) begin
                        w_state = w_match ? ADDR_ACK : WAIT_STOP;
                        w_oe    = w_match;
                        w_busy  = r_busy | w_match;
                        w_rw    = r_shift[0];
                        w_cnt   = 4'd0;
                    end
                    ADDR_ACK: if (r_cnt == 4'd1) begin
                        w_state = r_rw ? RDATA : (r_ptr_seen ? WDATA : PTR);
                        w_oe    = r_rw & ~w_rd_byte[7];
                        w_cnt   = 4'd0;
                    end
                    PTR: if (r_cnt == 4'd8) begin
                        w_ptr      = r_shift[REG_AW-1:0];
                        w_ptr_seen = 1'b1;
                        w_state    = PTR_ACK;
                        w_oe       = 1'b1;
                        w_cnt      = 4'd0;
                    end
                    WDATA: if (r_cnt == 4'd8) begin
                        w_state = WDATA_ACK;
                        w_oe    = 1'b1;
                        w_cnt   = 4'd0;
                    end
                    PTR_ACK, WDATA_ACK: if (r_cnt == 4'd1) begin
                        w_state = WDATA;
                        w_oe    = 1'b0;
                        w_cnt   = 4'd0;
                    end
                    RDATA: if (r_cnt == 4'd8) begin
                        w_state = RDATA_ACK;
                        w_oe    = 1'b0;
                        w_ptr   = r_ptr + PTR_ONE;
                        w_cnt   = 4'd0;
                    end else begin
                        w_oe = ~w_rd_byte[3'd7 - r_cnt[2:0]];
                    end
                    RDATA_ACK: if (r_cnt == 4'd1) begin
                        w_state = r_shift[0] ? WAIT_STOP : RDATA;
                        w_oe    = ~r_shift[0] & ~w_rd_byte[7];
                        w_cnt   = 4'd0;
                    end
                    default: ;
                endcase
            end
        end
    end
    // Protocol state, pointer and write-strobe registers
    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_shift     <= 8'h00;
            r_ptr       <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr_seen  <= 1'b0;
            r_rw        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_shift     <= w_shift;
            r_ptr       <= w_ptr;
            r_sda_oe    <= w_oe;
            r_busy      <= w_busy;
            r_ptr_seen  <= w_ptr_seen;
            r_rw        <= w_rw;
            r_wr_strobe <= w_we;
            r_wr_addr   <= w_we ? r_ptr : r_wr_addr;
            r_wr_data   <= w_we ? w_byte : r_wr_data;
        end
    end
    // Register file: cleared by reset, survives STOP, written on each completed data byte
    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'h00;
        end else if (w_we) begin
            r_regs[r_ptr] <= w_byte;
        end
    end
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed I2C controller bench with a table of write transactions plus corner sequences
module tb_i2c_target;
    localparam int Q = 10;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic scl = 1'b1;
    logic sda_ctl = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;
    logic [3:0] last_waddr = 4'h0;
    logic [7:0] last_wdata = 8'h00;
    i2c_target_if #(.REG_AW(4)) bus ();
    assign bus.scl_in = scl;
    assign bus.sda_in = sda_ctl & ~bus.sda_oe;
    i2c_target #(.DEV_ADDR(7'h39), .REG_AW(4)) dut (.clk_ref(clk), .reset_n(reset_n), .bus(bus));
    always #10 clk = ~clk;
    // Count write strobes and SDA pull-downs away from the active edge
    always @(negedge clk) begin
        if (bus.wr_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            last_waddr = bus.wr_addr;
            last_wdata = bus.wr_data;
        end
        if (bus.sda_oe) oe_cnt = oe_cnt + 1;
    end
    typedef struct {
        logic [6:0] addr;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
        logic [3:0] exp_waddr;
        logic [3:0] exp_state;
    } vec_t;
    vec_t vecs [7];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    task automatic wq(input int n);
        repeat (n) @(posedge clk);
    endtask
    task automatic i2c_start();
        sda_ctl = 1'b1; wq(Q);
        scl = 1'b1;     wq(Q);
        sda_ctl = 1'b0; wq(Q);
        scl = 1'b0;     wq(Q);
    endtask
    task automatic i2c_stop();
        sda_ctl = 1'b0; wq(Q);
        scl = 1'b1;     wq(Q);
        sda_ctl = 1'b1; wq(Q);
    endtask
    task automatic wr_bit(input logic b);
        sda_ctl = b; wq(Q);
        scl = 1'b1;  wq(2 * Q);
        scl = 1'b0;  wq(Q);
    endtask
    task automatic rd_bit(output logic b);
        sda_ctl = 1'b1; wq(Q);
        scl = 1'b1;     wq(Q);
        b = bus.sda_in; wq(Q);
        scl = 1'b0;     wq(Q);
    endtask
    task automatic wr_byte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wr_bit(v[i]);
        rd_bit(b);
        ack = ~b;
    endtask
    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rd_bit(b);
            d[i] = b;
        end
        wr_bit(nack);
    endtask
    initial begin
        logic ack;
        logic [7:0] d;
        int s0, o0;
        vecs[0] = '{7'h39, 8'h41, 8'h10, 1'b1, 4'h1, 4'd5};
        vecs[1] = '{7'h28, 8'h00, 8'h55, 1'b0, 4'h0, 4'd9};
        vecs[2] = '{7'h39, 8'hF7, 8'h5C, 1'b1, 4'h7, 4'd5};
        vecs[3] = '{7'h38, 8'h03, 8'h99, 1'b0, 4'h0, 4'd9};
        vecs[4] = '{7'h39, 8'h03, 8'hC3, 1'b1, 4'h3, 4'd5};
        vecs[5] = '{7'h39, 8'h04, 8'h3C, 1'b1, 4'h4, 4'd5};
        vecs[6] = '{7'h39, 8'h05, 8'h66, 1'b1, 4'h5, 4'd5};
        wq(5);
        @(negedge clk);
        check("rst_state", bus.state_out, 4'd0);
        check("rst_oe", bus.sda_oe, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_strobe", bus.wr_strobe, 1'b0);
        check("rst_waddr", bus.wr_addr, 4'h0);
        check("rst_wdata", bus.wr_data, 8'h00);
        reset_n = 1'b1;
        wq(5);
        // reset during the pointer-byte ACK
        i2c_start();
        wr_byte(8'h72, ack);
        check("mrst_addr_ack", ack, 1'b1);
        for (int i = 7; i >= 0; i--) wr_bit(i == 1);
        sda_ctl = 1'b1;
        wq(Q);
        @(negedge clk);
        check("mrst_oe_before", bus.sda_oe, 1'b1);
        check("mrst_state_before", bus.state_out, 4'd4);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_oe_after", bus.sda_oe, 1'b0);
        check("mrst_state_after", bus.state_out, 4'd0);
        wq(3);
        reset_n = 1'b1;
        scl = 1'b1; wq(2 * Q);
        scl = 1'b0; wq(Q);
        o0 = oe_cnt;
        wr_byte(8'h72, ack);
        check("mrst_ignored_state", bus.state_out, 4'd0);
        check("mrst_ignored_oe", oe_cnt - o0, 0);
        i2c_stop();
        s0 = strobe_cnt;
        i2c_start();
        wr_byte(8'h72, ack);
        check("post_rst_addr_ack", ack, 1'b1);
        wr_byte(8'h02, ack);
        check("post_rst_ptr_ack", ack, 1'b1);
        wr_byte(8'h5A, ack);
        check("post_rst_data_ack", ack, 1'b1);
        i2c_stop();
        check("post_rst_strobes", strobe_cnt - s0, 1);
        check("post_rst_waddr", last_waddr, 4'h2);
        check("post_rst_wdata", last_wdata, 8'h5A);
        // table of single-byte write transactions
        for (int v = 0; v < 7; v++) begin
            s0 = strobe_cnt;
            o0 = oe_cnt;
            i2c_start();
            wr_byte({vecs[v].addr, 1'b0}, ack);
            check($sformatf("v%0d_addr_ack", v), ack, vecs[v].exp_ack);
            wr_byte(vecs[v].ptr, ack);
            if (vecs[v].exp_ack) check($sformatf("v%0d_ptr_ack", v), ack, 1'b1);
            wr_byte(vecs[v].data, ack);
            if (vecs[v].exp_ack) begin
                check($sformatf("v%0d_data_ack", v), ack, 1'b1);
                check($sformatf("v%0d_waddr", v), last_waddr, vecs[v].exp_waddr);
                check($sformatf("v%0d_wdata", v), last_wdata, vecs[v].data);
            end else begin
                check($sformatf("v%0d_oe_quiet", v), oe_cnt - o0, 0);
            end
            check($sformatf("v%0d_strobes", v), strobe_cnt - s0, vecs[v].exp_ack ? 1 : 0);
            check($sformatf("v%0d_state", v), bus.state_out, vecs[v].exp_state);
            check($sformatf("v%0d_busy", v), bus.busy, vecs[v].exp_ack);
            i2c_stop();
            check($sformatf("v%0d_stop_state", v), bus.state_out, 4'd0);
            check($sformatf("v%0d_stop_busy", v), bus.busy, 1'b0);
        end
        // pointer write, repeated START, two-byte read
        i2c_start();
        wr_byte(8'h72, ack);
        wr_byte(8'h03, ack);
        i2c_start();
        wr_byte(8'h73, ack);
        check("rd_addr_ack", ack, 1'b1);
        rd_byte(1'b0, d);
        check("rd_byte0", d, 8'hC3);
        rd_byte(1'b1, d);
        check("rd_byte1", d, 8'h3C);
        check("rd_wait_stop", bus.state_out, 4'd9);
        i2c_stop();
        check("rd_idle", bus.state_out, 4'd0);
        // pointer wrap from 15 to 0
        s0 = strobe_cnt;
        i2c_start();
        wr_byte(8'h72, ack);
        wr_byte(8'h0F, ack);
        wr_byte(8'hAA, ack);
        wr_byte(8'hBB, ack);
        check("wrap_bb_ack", ack, 1'b1);
        i2c_stop();
        check("wrap_strobes", strobe_cnt - s0, 2);
        check("wrap_waddr", last_waddr, 4'h0);
        i2c_start();
        wr_byte(8'h72, ack);
        wr_byte(8'h0F, ack);
        i2c_start();
        wr_byte(8'h73, ack);
        rd_byte(1'b0, d);
        check("wrap_rd15", d, 8'hAA);
        rd_byte(1'b1, d);
        check("wrap_rd0", d, 8'hBB);
        i2c_stop();
        // STOP in the middle of a data byte
        s0 = strobe_cnt;
        i2c_start();
        wr_byte(8'h72, ack);
        wr_byte(8'h05, ack);
        wr_bit(1'b1); wr_bit(1'b0); wr_bit(1'b1); wr_bit(1'b0);
        i2c_stop();
        check("abort_strobes", strobe_cnt - s0, 0);
        check("abort_state", bus.state_out, 4'd0);
        i2c_start();
        wr_byte(8'h73, ack);
        rd_byte(1'b1, d);
        check("abort_ptr_kept", d, 8'h66);
        i2c_stop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
